// File: rtl/commutator_rr.sv
// commutator_rr: arbitrates ready channels and serialises the granted word into a header/length/data/checksum byte packet.
module commutator_rr #(
  parameter int N_CH     = 3,
  parameter int DATA_W   = 16,
  parameter int ARB_MODE = 1,
  parameter int CSUM_EN  = 1
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic [N_CH-1:0]          input_ready,
  input  logic [N_CH*DATA_W-1:0]   input_data,
  output logic [N_CH-1:0]          read_req,
  output logic                     output_valid,
  input  logic                     output_ready,
  output logic [7:0]               output_data
);
  localparam int BYTES = DATA_W / 8;
  localparam logic [3:0] LAST = 4'(BYTES - 1);
  typedef enum logic [2:0] {IDLE, HDR, LEN, DATA, CSUM} state_t;
  state_t state_q;
  logic [3:0] ptr_q, cnt_q, gnt_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [7:0] csum_q, first_d, next_d;
  logic [N_CH-1:0] rot_d;
  int base_d;
  // Rotate the request vector so the search always starts at bit 0, then map the winner back.
  always_comb begin
    base_d = ARB_MODE != 0 ? (int'(ptr_q) + 1) % N_CH : 0;
    rot_d = N_CH'({input_ready, input_ready} >> base_d);
    gnt_d = '0;
    for (int k = N_CH - 1; k >= 0; k--) gnt_d = rot_d[k] ? 4'((base_d + k) % N_CH) : gnt_d;
    word_d = DATA_W'(input_data >> (int'(gnt_d) * DATA_W));
    first_d = 8'(word_q >> {LAST, 3'b000});
    next_d = 8'(word_q >> {LAST - cnt_q - 4'd1, 3'b000});
  end
  always_ff @(posedge clk) begin
    if (arst) begin
      state_q <= IDLE;
      output_valid <= 1'b0;
      output_data <= 8'h00;
      read_req <= '0;
      ptr_q <= 4'(N_CH - 1);
      cnt_q <= '0;
      csum_q <= 8'h00;
      word_q <= '0;
    end else begin
      read_req <= '0;
      case (state_q)
        IDLE: if (|input_ready) begin
          state_q <= HDR;
          output_valid <= 1'b1;
          output_data <= {4'hF, gnt_d};
          csum_q <= {4'hF, gnt_d};
          read_req <= N_CH'(1) << gnt_d;
          word_q <= word_d;
          ptr_q <= gnt_d;
        end
        HDR: if (output_ready) begin
          state_q <= LEN;
          output_data <= 8'(BYTES);
          csum_q <= csum_q ^ 8'(BYTES);
        end
        LEN: if (output_ready) begin
          state_q <= DATA;
          cnt_q <= '0;
          output_data <= first_d;
          csum_q <= csum_q ^ first_d;
        end
        DATA: if (output_ready) begin
          if (cnt_q != LAST) begin
            cnt_q <= cnt_q + 4'd1;
            output_data <= next_d;
            csum_q <= csum_q ^ next_d;
          end else if (CSUM_EN != 0) begin
            state_q <= CSUM;
            output_data <= csum_q;
          end else begin
            state_q <= IDLE;
            output_valid <= 1'b0;
            output_data <= 8'h00;
          end
        end
        CSUM: if (output_ready) begin
          state_q <= IDLE;
          output_valid <= 1'b0;
          output_data <= 8'h00;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_commutator_rr.sv
// tb_commutator_rr: three configurations (round-robin, fixed priority, 32-bit without checksum) against a packet-queue model.
module tb_commutator_rr;
  logic clk = 1'b0;
  logic arst = 1'b1;
  logic [2:0] rdy = '0;
  logic oready = 1'b1;
  logic [31:0] w [3];
  logic [47:0] din16;
  logic [95:0] din32;
  logic [2:0] ov;
  logic [2:0][7:0] od;
  logic [2:0][2:0] rq;
  int pass_cnt = 0, total_cnt = 0;
  logic [7:0] pk [3][8];
  int plen [3] = '{0, 0, 0};
  int ppos [3] = '{0, 0, 0};
  int mptr [3] = '{2, 2, 2};
  logic [2:0] exp_rr [3];
  logic [2:0] pv = '0;
  logic [7:0] pod [3];
  logic [7:0] lg0 [$], lg2 [$], hd0 [$], hd1 [$];

  always #5 clk = ~clk;
  assign din16 = {w[2][15:0], w[1][15:0], w[0][15:0]};
  assign din32 = {w[2], w[1], w[0]};

  commutator_rr #(.N_CH(3), .DATA_W(16), .ARB_MODE(1), .CSUM_EN(1)) u_rr (
    .clk(clk), .arst(arst), .input_ready(rdy), .input_data(din16), .read_req(rq[0]),
    .output_valid(ov[0]), .output_ready(oready), .output_data(od[0]));
  commutator_rr #(.N_CH(3), .DATA_W(16), .ARB_MODE(0), .CSUM_EN(1)) u_fp (
    .clk(clk), .arst(arst), .input_ready(rdy), .input_data(din16), .read_req(rq[1]),
    .output_valid(ov[1]), .output_ready(oready), .output_data(od[1]));
  commutator_rr #(.N_CH(3), .DATA_W(32), .ARB_MODE(1), .CSUM_EN(0)) u_w32 (
    .clk(clk), .arst(arst), .input_ready(rdy), .input_data(din32), .read_req(rq[2]),
    .output_valid(ov[2]), .output_ready(oready), .output_data(od[2]));

  task automatic chk(input string nm, input int d, input logic [7:0] got, input logic [7:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s dut%0d: got %h want %h", nm, d, got, exp);
  endtask

  // One model step per edge: idle means the whole expected packet has been consumed.
  task automatic model_step(input int d, input bit arb, input int nb, input bit cs);
    int g;
    logic [7:0] x;
    exp_rr[d] = '0;
    if (arst) begin
      plen[d] = 0; ppos[d] = 0; mptr[d] = 2;
    end else if (ppos[d] < plen[d]) begin
      if (oready) ppos[d]++;
    end else if (|rdy) begin
      g = -1;
      for (int k = 1; k <= 3; k++) begin
        int c;
        c = arb ? (mptr[d] + k) % 3 : k - 1;
        if (g < 0 && rdy[c]) g = c;
      end
      pk[d][0] = 8'hF0 | 8'(g);
      pk[d][1] = 8'(nb);
      x = pk[d][0] ^ pk[d][1];
      for (int i = 0; i < nb; i++) begin
        pk[d][2+i] = w[g][8*(nb-1-i) +: 8];
        x ^= pk[d][2+i];
      end
      plen[d] = 2 + nb;
      if (cs) begin pk[d][plen[d]] = x; plen[d]++; end
      ppos[d] = 0;
      exp_rr[d] = 3'(1 << g);
      mptr[d] = g;
    end
  endtask

  initial forever begin
    bit busy;
    @(posedge clk);
    if (pv[0] && oready) lg0.push_back(pod[0]);
    if (pv[2] && oready) lg2.push_back(pod[2]);
    model_step(0, 1'b1, 2, 1'b1);
    model_step(1, 1'b0, 2, 1'b1);
    model_step(2, 1'b1, 4, 1'b0);
    #1;
    for (int d = 0; d < 3; d++) begin
      busy = ppos[d] < plen[d];
      chk("valid", d, {7'd0, ov[d]}, {7'd0, busy});
      chk("data", d, od[d], busy ? pk[d][ppos[d]] : 8'h00);
      chk("read_req", d, {5'd0, rq[d]}, {5'd0, exp_rr[d]});
      pv[d] = ov[d];
      pod[d] = od[d];
    end
    if (rq[0] != 0) hd0.push_back(od[0]);
    if (rq[1] != 0) hd1.push_back(od[1]);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_log(input string nm, input int d, input logic [7:0] q [$], input logic [7:0] exp [$]);
    chk({nm, "_len"}, d, 8'(q.size()), 8'(exp.size()));
    for (int i = 0; i < exp.size() && i < q.size(); i++) chk(nm, d, q[i], exp[i]);
  endtask

  initial begin
    int n1;
    logic [2:0] nr;
    w = '{32'h0, 32'h0, 32'h0};
    cyc(2);
    chk("rst_valid", 0, {7'd0, ov[0]}, 8'h00);
    chk("rst_data", 0, od[0], 8'h00);
    chk("rst_rr", 0, {5'd0, rq[0]}, 8'h00);
    arst = 1'b0;
    cyc(1);
    lg0.delete(); lg2.delete();
    w[1] = 32'h0000A55A; rdy = 3'b010;
    cyc(1); rdy = '0; cyc(8);
    chk_log("pkt_a55a", 0, lg0, '{8'hF1, 8'h02, 8'hA5, 8'h5A, 8'h0C});
    lg2.delete();
    w[2] = 32'h01020304; rdy = 3'b100;
    cyc(1); rdy = '0; cyc(10);
    chk_log("pkt_w32", 2, lg2, '{8'hF2, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04});
    hd0.delete(); hd1.delete();
    w[0] = 32'h1111; w[1] = 32'h2222; w[2] = 32'h3333; rdy = 3'b111;
    cyc(32);
    n1 = hd1.size();
    rdy = 3'b110; cyc(20); rdy = '0; cyc(10);
    chk_log("rr_hdr", 0, hd0[0:4], '{8'hF0, 8'hF1, 8'hF2, 8'hF0, 8'hF1});
    for (int i = 0; i < n1; i++) chk("fp_hdr", 1, hd1[i], 8'hF0);
    chk("fp_hdr_drop", 1, hd1[hd1.size()-1], 8'hF1);
    lg0.delete();
    w[0] = 32'h1234; rdy = 3'b001;
    cyc(1); rdy = '0; cyc(1);
    oready = 1'b0; cyc(3);
    chk("bp_valid", 0, {7'd0, ov[0]}, 8'h01);
    chk("bp_data", 0, od[0], 8'h02);
    oready = 1'b1; cyc(8);
    chk_log("pkt_bp", 0, lg0, '{8'hF0, 8'h02, 8'h12, 8'h34, 8'hD4});
    w[1] = 32'hABCD; rdy = 3'b010;
    cyc(1); rdy = '0; cyc(3);
    chk("pre_rst_data", 0, od[0], 8'hCD);
    arst = 1'b1; cyc(1); arst = 1'b0;
    chk("mid_rst_valid", 0, {7'd0, ov[0]}, 8'h00);
    chk("mid_rst_rr", 0, {5'd0, rq[0]}, 8'h00);
    lg0.delete(); hd0.delete();
    rdy = 3'b011; cyc(1); rdy = '0; cyc(8);
    chk_log("post_rst", 0, lg0, '{8'hF0, 8'h02, 8'h12, 8'h34, 8'hD4});
    for (int c = 0; c < 2000; c++) begin
      nr = 3'($urandom);
      for (int i = 0; i < 3; i++) if (!rdy[i]) w[i] = $urandom;
      rdy = nr;
      oready = $urandom_range(0, 3) != 0;
      arst = $urandom_range(0, 299) == 0;
      cyc(1);
    end
    arst = 1'b0; rdy = '0; oready = 1'b1;
    cyc(12);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
